// File: rtl/spi_frame_rx_if.sv
// Bus bundle between the SPI frame receiver and its neighbours: the SPI pins
// on one side and the decoded strobes/fields plus read data on the other.
interface spi_frame_rx_if;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] rdata;
    logic        status_ready;
    logic [3:0]  status;
    logic        address_ready;
    logic [19:0] addr;
    logic        data_ready;
    logic [15:0] wdata;
    logic        miso_start;
    logic        rdata_read;
    logic        cs_n_o;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, rdata,
        output spi_miso, status_ready, status, address_ready, addr,
               data_ready, wdata, miso_start, rdata_read, cs_n_o
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, rdata,
        input  spi_miso, status_ready, status, address_ready, addr,
               data_ready, wdata, miso_start, rdata_read, cs_n_o
    );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end, oversampled in the clk domain. Decodes a
// 4-bit status + 20-bit address header, then either collects 16-bit write
// words or shifts out 16-bit read words after RD_DUMMY_BITS dummy clocks.
module spi_frame_rx #(
    parameter int unsigned RD_DUMMY_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    spi_frame_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, STATUS, ADDR, WR_DATA, RD_DUMMY, RD_DATA, DONE
    } state_t;

    localparam logic [4:0] DUMMY_LAST = 5'(RD_DUMMY_BITS - 1);

    logic [2:0]  sclk_sync;
    logic [1:0]  mosi_sync;
    logic        cs_meta;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_bit;

    state_t      state;
    logic [4:0]  cnt;
    logic [18:0] shreg;
    logic [19:0] shifted;
    logic [15:0] tx;
    logic        loaded;
    logic        armed;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign mosi_bit  = mosi_sync[1];
    assign shifted   = {shreg, mosi_bit};

    // First cs_n stage is left out of reset so that right after reset it
    // already holds the real pin level; this keeps a frame still in progress
    // from being mistaken for a fresh one.
    always_ff @(posedge clk) begin
        cs_meta <= bus.spi_cs_n;
    end

    // Pin synchronisers; cs_n_o is the second chip-select stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            bus.cs_n_o <= 1'b1;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], bus.spi_sclk};
            mosi_sync  <= {mosi_sync[0], bus.spi_mosi};
            bus.cs_n_o <= cs_meta;
        end
    end

    // Frame FSM: shifts fields on sclk rises, drives MISO on falls, emits strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            shreg             <= '0;
            tx                <= '0;
            loaded            <= 1'b0;
            armed             <= 1'b0;
            bus.spi_miso      <= 1'b0;
            bus.status_ready  <= 1'b0;
            bus.status        <= '0;
            bus.address_ready <= 1'b0;
            bus.addr          <= '0;
            bus.data_ready    <= 1'b0;
            bus.wdata         <= '0;
            bus.miso_start    <= 1'b0;
            bus.rdata_read    <= 1'b0;
        end else begin
            bus.status_ready  <= 1'b0;
            bus.address_ready <= 1'b0;
            bus.data_ready    <= 1'b0;
            bus.miso_start    <= 1'b0;
            bus.rdata_read    <= 1'b0;

            if (bus.cs_n_o) begin
                // Deselect overrides any sclk edge in the same cycle; only a
                // genuinely high chip select (both stages) re-arms after reset.
                state        <= IDLE;
                cnt          <= '0;
                shreg        <= '0;
                loaded       <= 1'b0;
                bus.spi_miso <= 1'b0;
                if (cs_meta) armed <= 1'b1;
            end else begin
                if (state != RD_DATA) bus.spi_miso <= 1'b0;
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state <= STATUS;
                            cnt   <= '0;
                            shreg <= '0;
                        end
                    end
                    STATUS: begin
                        if (sclk_rise) begin
                            if (cnt == 5'd3) begin
                                bus.status       <= shifted[3:0];
                                bus.status_ready <= 1'b1;
                                cnt              <= '0;
                                shreg            <= '0;
                                state            <= ADDR;
                            end else begin
                                shreg <= shifted[18:0];
                                cnt   <= cnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            if (cnt == 5'd19) begin
                                bus.addr          <= shifted;
                                bus.address_ready <= 1'b1;
                                cnt               <= '0;
                                shreg             <= '0;
                                state             <= bus.status[2] ? WR_DATA : RD_DUMMY;
                            end else begin
                                shreg <= shifted[18:0];
                                cnt   <= cnt + 5'd1;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (sclk_rise) begin
                            if (cnt == 5'd15) begin
                                bus.wdata      <= shifted[15:0];
                                bus.data_ready <= 1'b1;
                                cnt            <= '0;
                                shreg          <= '0;
                                state          <= bus.status[1] ? WR_DATA : DONE;
                            end else begin
                                shreg <= shifted[18:0];
                                cnt   <= cnt + 5'd1;
                            end
                        end
                    end
                    RD_DUMMY: begin
                        if (sclk_rise) begin
                            if (cnt == DUMMY_LAST) begin
                                bus.miso_start <= 1'b1;
                                cnt            <= '0;
                                loaded         <= 1'b0;
                                state          <= RD_DATA;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (sclk_fall) begin
                            if (!loaded) begin
                                bus.spi_miso <= bus.rdata[15];
                                tx           <= {bus.rdata[14:0], 1'b0};
                                loaded       <= 1'b1;
                            end else begin
                                bus.spi_miso <= tx[15];
                                tx           <= {tx[14:0], 1'b0};
                            end
                        end
                        if (sclk_rise) begin
                            if (cnt == 5'd15) begin
                                bus.rdata_read <= 1'b1;
                                cnt            <= '0;
                                loaded         <= 1'b0;
                                state          <= bus.status[1] ? RD_DUMMY : DONE;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                    DONE: begin
                        cnt <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
